// File: rtl/life_io_ctrl.sv
// Host-side load / run / readout sequencer for a ROWS x COLS Life cell array.
// Define LIFE_IO_CTRL_POPCOUNT_EN to add the live_count tally of streamed-out live cells.
module life_io_ctrl #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [GEN_W-1:0] cmd_gens,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             wr_bit,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_bit,
  output logic             busy,
  output logic [ROWS-1:0]  row_load,
  output logic [COLS-1:0]  col_data,
  output logic             run,
  output logic             load_out,
  output logic             shift,
  input  logic             chain_tail,
`ifdef LIFE_IO_CTRL_POPCOUNT_EN
  output logic [$clog2(ROWS*COLS+1)-1:0] live_count,
`endif
  inout  wire              vccd1,
  inout  wire              vssd1
);

  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BW    = $clog2(NCELL + 1);

  localparam logic [CW-1:0]    ColLast  = CW'(COLS - 1);
  localparam logic [RW-1:0]    RowLast  = RW'(ROWS - 1);
  localparam logic [BW-1:0]    BcntLast = BW'(NCELL - 1);
  localparam logic [GEN_W-1:0] GenOne   = GEN_W'(1);

  localparam logic [1:0] OpLoad = 2'd0;
  localparam logic [1:0] OpRun  = 2'd1;
  localparam logic [1:0] OpRead = 2'd2;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoadCol = 3'd1;
  localparam logic [2:0] StLoadRow = 3'd2;
  localparam logic [2:0] StRun     = 3'd3;
  localparam logic [2:0] StCapture = 3'd4;
  localparam logic [2:0] StRead    = 3'd5;

  logic [2:0]       r_state, w_state_d;
  logic [CW-1:0]    r_col, w_col_d;
  logic [RW-1:0]    r_row, w_row_d;
  logic [GEN_W-1:0] r_gcnt, w_gcnt_d;
  logic [BW-1:0]    r_bcnt, w_bcnt_d;
  logic [COLS-1:0]  r_col_data, w_col_data_d;
  logic [ROWS-1:0]  r_row_load, w_row_onehot;
  logic             r_run, r_load_out, r_shift, w_shift_d;
  logic             w_cmd_fire, w_wr_fire, w_rd_valid, w_rd_fire;
  logic             w_unused_pwr;

  assign w_unused_pwr = vccd1 ^ vssd1;

  assign cmd_ready  = (r_state == StIdle) & ~reset;
  assign busy       = (r_state != StIdle);
  assign wr_ready   = (r_state == StLoadCol);
  // rd_valid drops during the shift cycle so chain_tail has a cycle to settle.
  assign w_rd_valid = (r_state == StRead) & ~r_shift;
  assign rd_valid   = w_rd_valid;
  assign rd_bit     = w_rd_valid & chain_tail;

  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_wr_fire  = wr_valid & wr_ready;
  assign w_rd_fire  = w_rd_valid & rd_ready;

  assign row_load = r_row_load;
  assign col_data = r_col_data;
  assign run      = r_run;
  assign load_out = r_load_out;
  assign shift    = r_shift;

  always_comb begin
    w_state_d    = r_state;
    w_col_d      = r_col;
    w_row_d      = r_row;
    w_gcnt_d     = r_gcnt;
    w_bcnt_d     = r_bcnt;
    w_col_data_d = r_col_data;
    w_shift_d    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_cmd_fire) begin
          unique case (cmd_op)
            OpLoad: begin
              w_state_d = StLoadCol;
              w_row_d   = '0;
              w_col_d   = '0;
            end
            OpRun: begin
              if (cmd_gens != '0) begin
                w_state_d = StRun;
                w_gcnt_d  = cmd_gens;
              end
            end
            OpRead:  w_state_d = StCapture;
            default: ;
          endcase
        end
      end
      StLoadCol: begin
        if (w_wr_fire) begin
          w_col_data_d[r_col] = wr_bit;
          if (r_col == ColLast) begin
            w_state_d = StLoadRow;
            w_col_d   = '0;
          end else begin
            w_col_d = r_col + 1'b1;
          end
        end
      end
      StLoadRow: begin
        w_col_d   = '0;
        w_row_d   = r_row + 1'b1;
        w_state_d = (r_row == RowLast) ? StIdle : StLoadCol;
      end
      StRun: begin
        w_gcnt_d = r_gcnt - 1'b1;
        if (r_gcnt == GenOne) w_state_d = StIdle;
      end
      StCapture: begin
        w_bcnt_d  = '0;
        w_state_d = StRead;
      end
      StRead: begin
        if (w_rd_fire) begin
          w_bcnt_d = r_bcnt + 1'b1;
          if (r_bcnt == BcntLast) w_state_d = StIdle;
          else                    w_shift_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_row_onehot          = '0;
    w_row_onehot[w_row_d] = 1'b1;
  end

  // Array controls are decoded from the next state so they are pure flop outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_col      <= '0;
      r_row      <= '0;
      r_gcnt     <= '0;
      r_bcnt     <= '0;
      r_col_data <= '0;
      r_row_load <= '0;
      r_run      <= 1'b0;
      r_load_out <= 1'b0;
      r_shift    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_col      <= w_col_d;
      r_row      <= w_row_d;
      r_gcnt     <= w_gcnt_d;
      r_bcnt     <= w_bcnt_d;
      r_col_data <= w_col_data_d;
      r_row_load <= (w_state_d == StLoadRow) ? w_row_onehot : '0;
      r_run      <= (w_state_d == StRun);
      r_load_out <= (w_state_d == StCapture);
      r_shift    <= w_shift_d;
    end
  end

`ifdef LIFE_IO_CTRL_POPCOUNT_EN
  logic [BW-1:0] r_live_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live_count <= '0;
    end else if (r_state == StCapture) begin
      r_live_count <= '0;
    end else if (w_rd_fire && chain_tail) begin
      r_live_count <= r_live_count + 1'b1;
    end
  end

  assign live_count = r_live_count;
`endif

endmodule

// File: tb/tb_life_io_ctrl.sv
// Directed bench for life_io_ctrl on a 4x4 array, with a behavioural Life array and output chain.
module tb_life_io_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int GEN_W = 16;
  localparam int NB    = ROWS * COLS;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_READ = 2'd2;
  localparam logic [1:0] OP_NOP  = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [GEN_W-1:0] cmd_gens;
  logic             wr_valid, wr_ready, wr_bit;
  logic             rd_valid, rd_ready, rd_bit;
  logic             busy;
  logic [ROWS-1:0]  row_load;
  logic [COLS-1:0]  col_data;
  logic             run, load_out, shift, chain_tail;
  wire              vccd1;
  wire              vssd1;
  assign vccd1 = 1'b1;
  assign vssd1 = 1'b0;
`ifdef LIFE_IO_CTRL_POPCOUNT_EN
  logic [4:0]       live_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  life_io_ctrl #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_gens   (cmd_gens),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_bit     (wr_bit),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_bit     (rd_bit),
    .busy       (busy),
    .row_load   (row_load),
    .col_data   (col_data),
    .run        (run),
    .load_out   (load_out),
    .shift      (shift),
    .chain_tail (chain_tail),
`ifdef LIFE_IO_CTRL_POPCOUNT_EN
    .live_count (live_count),
`endif
    .vccd1      (vccd1),
    .vssd1      (vssd1)
  );

  // Behavioural cell array: dead boundary, chain index r*COLS+c, index 0 leaves first.
  logic [COLS-1:0] grid [ROWS] = '{default: '0};
  logic [NB-1:0]   chain = '0;
  assign chain_tail = chain[0];

  function automatic logic next_cell(int r, int c);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < ROWS && c + dc >= 0 && c + dc < COLS)
          n += int'(grid[r+dr][c+dc]);
    return (n == 3) || (n == 2 && grid[r][c]);
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (row_load[r]) grid[r][c] <= col_data[c];
        else if (run)    grid[r][c] <= next_cell(r, c);
      end
    if (load_out) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) chain[r*COLS+c] <= grid[r][c];
    end else if (shift) begin
      chain <= {1'b0, chain[NB-1:1]};
    end
  end

  // Pulse counters and a log of {row_load, col_data} for every row strobe cycle.
  int n_run = 0, n_lo = 0, n_sh = 0, n_overlap = 0;
  logic [7:0] rl_log[$];
  always @(posedge clk) begin
    if (run)      n_run <= n_run + 1;
    if (load_out) n_lo  <= n_lo + 1;
    if (shift)    n_sh  <= n_sh + 1;
    if (run && row_load != '0) n_overlap <= n_overlap + 1;
    if (row_load != '0) rl_log.push_back({row_load, col_data});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [GEN_W-1:0] g);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_gens  = g;
    while (!cmd_ready && guard < 500) begin
      tick();
      guard++;
    end
    check("cmd_ready_seen", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  task automatic load_rows(input logic [NB-1:0] pat, input int nbits);
    int guard;
    send_cmd(OP_LOAD, '0);
    for (int i = 0; i < nbits; i++) begin
      wr_valid = 1'b1;
      wr_bit   = pat[i];
      guard    = 0;
      while (!wr_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (!wr_ready) check("wr_ready_seen", {31'b0, wr_ready}, 32'd1);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input int stall_at, input int stall_len,
                         output logic [NB-1:0] bits, output int nbits);
    int guard = 0;
    logic held;
    int sh0;
    bits     = '0;
    nbits    = 0;
    rd_ready = 1'b1;
    send_cmd(OP_READ, '0);
    while (busy && guard < 400) begin
      if (rd_valid) begin
        if (nbits == stall_at && stall_len > 0) begin
          rd_ready = 1'b0;
          held     = rd_bit;
          sh0      = n_sh;
          repeat (stall_len) begin
            tick();
            check("stall_rd_valid", {31'b0, rd_valid}, 32'd1);
            check("stall_rd_bit", {31'b0, rd_bit}, {31'b0, held});
          end
          check("stall_no_shift", n_sh, sh0);
          rd_ready = 1'b1;
        end
        if (nbits < NB) bits[nbits] = rd_bit;
        nbits++;
      end
      tick();
      guard++;
    end
    check("read_done", {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [GEN_W-1:0] gens;
    int               busy_cyc;
    int               runs;
    int               los;
    int               shs;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, r0, lo0, sh0, base, nbits;
    logic [NB-1:0] bits;

    vecs[0] = '{OP_NOP,  16'd0, 0,  0, 0, 0};
    vecs[1] = '{OP_RUN,  16'd0, 0,  0, 0, 0};
    vecs[2] = '{OP_RUN,  16'd3, 3,  3, 0, 0};
    vecs[3] = '{OP_RUN,  16'd1, 1,  1, 0, 0};
    vecs[4] = '{OP_READ, 16'd0, 32, 0, 1, 15};
    vecs[5] = '{OP_RUN,  16'd5, 5,  5, 0, 0};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_gens  = '0;
    wr_valid  = 1'b0;
    wr_bit    = 1'b0;
    rd_ready  = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_row_load", {28'b0, row_load}, 32'd0);
    check("rst_ctrl", {29'b0, run, load_out, shift}, 32'd0);
    check("rst_hs", {30'b0, rd_valid, wr_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    tick();

    for (int i = 0; i < 6; i++) begin
      r0  = n_run;
      lo0 = n_lo;
      sh0 = n_sh;
      send_cmd(vecs[i].op, vecs[i].gens);
      wait_idle(cyc);
      tick();
      check($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].busy_cyc);
      check($sformatf("v%0d_run_pulses", i), n_run - r0, vecs[i].runs);
      check($sformatf("v%0d_load_out", i), n_lo - lo0, vecs[i].los);
      check($sformatf("v%0d_shifts", i), n_sh - sh0, vecs[i].shs);
      check($sformatf("v%0d_cmd_ready", i), {31'b0, cmd_ready}, 32'd1);
    end

    // Vertical blinker in column 1, rows 0..2.
    base = rl_log.size();
    load_rows(16'h0222, NB);
    wait_idle(cyc);
    tick();
    check("load_row_cycles", rl_log.size() - base, 32'd4);
    if (rl_log.size() >= base + 4) begin
      check("load_row0", rl_log[base],   8'h12);
      check("load_row1", rl_log[base+1], 8'h22);
      check("load_row2", rl_log[base+2], 8'h42);
      check("load_row3", rl_log[base+3], 8'h80);
    end

    r0 = n_run;
    send_cmd(OP_RUN, 16'd1);
    wait_idle(cyc);
    tick();
    check("blinker_run", n_run - r0, 32'd1);

    lo0 = n_lo;
    sh0 = n_sh;
    do_read(-1, 0, bits, nbits);
    tick();
    check("blinker_nbits", nbits, 32'd16);
    check("blinker_bits", {16'b0, bits}, 32'h0070);
    check("blinker_load_out", n_lo - lo0, 32'd1);
    check("blinker_shifts", n_sh - sh0, 32'd15);
`ifdef LIFE_IO_CTRL_POPCOUNT_EN
    check("live_count", {27'b0, live_count}, 32'd3);
`endif

    sh0 = n_sh;
    do_read(4, 2, bits, nbits);
    tick();
    check("stall_nbits", nbits, 32'd16);
    check("stall_bits", {16'b0, bits}, 32'h0070);
    check("stall_shifts", n_sh - sh0, 32'd15);

    // Second command offered while busy must wait for IDLE.
    r0 = n_run;
    send_cmd(OP_RUN, 16'd5);
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    cmd_gens  = 16'd2;
    tick();
    check("b2b_not_ready", {30'b0, cmd_ready, busy}, 32'd1);
    send_cmd(OP_RUN, 16'd2);
    wait_idle(cyc);
    tick();
    check("b2b_run_total", n_run - r0, 32'd7);

    // Reset in the middle of a load.
    load_rows(16'h0003, 2);
    check("pre_rst_col_data", {28'b0, col_data}, 32'h3);
    reset = 1'b1;
    #1;
    check("arst_row_col", {24'b0, row_load, col_data}, 32'd0);
    check("arst_ctrl", {29'b0, run, load_out, shift}, 32'd0);
    check("arst_hs", {28'b0, rd_valid, wr_ready, busy, cmd_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("arst_rel_ready", {31'b0, cmd_ready}, 32'd1);
    tick();

    base = rl_log.size();
    load_rows(16'hF681, NB);
    wait_idle(cyc);
    tick();
    check("reload_row_cycles", rl_log.size() - base, 32'd4);
    if (rl_log.size() >= base + 4) begin
      check("reload_row0", rl_log[base],   8'h11);
      check("reload_row1", rl_log[base+1], 8'h28);
      check("reload_row2", rl_log[base+2], 8'h46);
      check("reload_row3", rl_log[base+3], 8'h8F);
    end

    check("run_rowload_overlap", n_overlap, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
